// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: 16x-oversampled serial receiver that packs bytes into 32-bit words held in a show-ahead FIFO.
// Parameters: CLK_DIV clk cycles per oversample tick, DEPTH FIFO words (power of two), ADDR_W = log2(DEPTH).
// Ports: clk, reset (sync, active-low), rx (async serial in, idle high, 8N1 LSB first),
//   rd_en (pop), clr_err (clear sticky flags), data_out (head word), valid (not empty), full,
//   level (stored words), overrun / frame_err / parity_err (sticky error flags).
// Optional feature: define RX_PARITY_EN to receive an even-parity bit after the data bits;
//   without it the frame is 10 bits and parity_err is tied low.
module serial_rx_fifo #(
  parameter int CLK_DIV = 27,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [31:0]       data_out,
  output logic              valid,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  output logic              frame_err,
  output logic              parity_err
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`ifdef RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

  // rx_d is the previous synchronized sample, used only for falling-edge detection
  logic rx_s1, rx_s2, rx_d;
  always_ff @(posedge clk)
    if (!reset) {rx_s1, rx_s2, rx_d} <= 3'b111;
    else {rx_s1, rx_s2, rx_d} <= {rx, rx_s1, rx_s2};

  logic [15:0] div_cnt;
  logic tick;
  assign tick = div_cnt == DIV_MAX;
  always_ff @(posedge clk)
    if (!reset || tick) div_cnt <= 16'd0;
    else div_cnt <= div_cnt + 16'd1;

  state_t state, state_n;
  logic [3:0] tcnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic mid_start, bit_end, accept, ferr;
  assign mid_start = tick && tcnt == 4'd7;
  assign bit_end = tick && tcnt == 4'd15;
`ifdef RX_PARITY_EN
  logic perr, par_bad;
`endif

  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    accept = 1'b0;
    ferr = 1'b0;
`ifdef RX_PARITY_EN
    perr = 1'b0;
`endif
    case (state)
      IDLE: if (rx_d && !rx_s2) state_n = START;
      START: if (mid_start) state_n = rx_s2 ? IDLE : DATA;
      DATA: if (bit_end && bit_cnt == 3'd7) state_n = AFTER_DATA;
`ifdef RX_PARITY_EN
      // even parity: the parity bit must equal the XOR of the data bits
      PARITY: if (bit_end) begin
        state_n = STOP;
        perr = rx_s2 != ^shreg;
      end
`endif
      STOP: if (bit_end) begin
        state_n = rx_s2 ? IDLE : WAIT_HIGH;
        ferr = !rx_s2;
`ifdef RX_PARITY_EN
        accept = rx_s2 && !par_bad;
`else
        accept = rx_s2;
`endif
      end
      WAIT_HIGH: if (rx_s2) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // tcnt restarts at the start-bit centre so every later sample lands 16 ticks apart
  always_ff @(posedge clk)
    if (!reset) begin
      tcnt <= 4'd0;
      bit_cnt <= 3'd0;
      shreg <= 8'd0;
    end else begin
      tcnt <= (state == IDLE || (state == START && mid_start)) ? 4'd0 : tcnt + {3'd0, tick};
      bit_cnt <= (state == DATA) ? bit_cnt + {2'd0, bit_end} : 3'd0;
      if (state == DATA && bit_end) shreg <= {rx_s2, shreg[7:1]};
    end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk)
    if (!reset) par_bad <= 1'b0;
    else par_bad <= (state == START) ? 1'b0 : par_bad | perr;
`endif

  // word is written to the FIFO the cycle after its 4th byte lands, so it is stable then
  logic [1:0] byte_cnt;
  logic [31:0] word;
  logic push_req;
  always_ff @(posedge clk)
    if (!reset) begin
      byte_cnt <= 2'd0;
      word <= 32'd0;
      push_req <= 1'b0;
    end else begin
      push_req <= accept && byte_cnt == 2'd3;
      if (accept) begin
        word[{byte_cnt, 3'b000} +: 8] <= shreg;
        byte_cnt <= byte_cnt + 2'd1;
      end
    end

  logic [31:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic pop, wr;
  assign pop = rd_en && valid;
  assign wr = push_req && (!full || pop);
  // level never exceeds DEPTH = 2**ADDR_W, so its MSB alone marks full
  assign valid = |level;
  assign full = level[ADDR_W];
  assign data_out = valid ? mem[rptr] : 32'd0;

  always_ff @(posedge clk)
    if (wr) mem[wptr] <= word;

  always_ff @(posedge clk)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      wptr <= wptr + {{(ADDR_W-1){1'b0}}, wr};
      rptr <= rptr + {{(ADDR_W-1){1'b0}}, pop};
      level <= level + {{ADDR_W{1'b0}}, wr} - {{ADDR_W{1'b0}}, pop};
    end

  // a new error event outranks clr_err in the same cycle
  always_ff @(posedge clk)
    if (!reset) begin
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun <= (push_req && full && !pop) || (overrun && !clr_err);
      frame_err <= ferr || (frame_err && !clr_err);
    end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk)
    if (!reset) parity_err <= 1'b0;
    else parity_err <= perr || (parity_err && !clr_err);
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: doc/serial_rx_fifo.md
SERIAL_RX_FIFO -- requirements
Module: serial_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27, clk cycles per 1/16-bit oversample tick.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO depth in 32-bit words (power of two).
REQ-003 SHALL have parameter ADDR_W, default 4, log2(DEPTH).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high, 8 data bits LSB first, 1 stop bit.
REQ-007 SHALL have port rd_en  input  1  pop strobe from processor.
REQ-008 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-009 SHALL have port data_out  output  32  head-of-FIFO word (show-ahead).
REQ-010 SHALL have port valid  output  1  FIFO not empty.
REQ-011 SHALL have port full  output  1  FIFO holds DEPTH words.
REQ-012 SHALL have port level  output  ADDR_W+1  number of stored words.
REQ-013 SHALL have port overrun  output  1  sticky, word dropped on full.
REQ-014 SHALL have port frame_err  output  1  sticky, stop bit sampled low.
REQ-015 SHALL have port parity_err  output  1  sticky, parity mismatch (see Configuration).

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer before any use; the synchronizer adds 2 cycles of latency.
REQ-017 SHALL generate a one-cycle tick every CLK_DIV clocks from a free-running counter that reloads on reset only.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-019 IDLE -> START on synchronized rx high-to-low; the tick counter within the bit SHALL clear to 0.
REQ-020 START: at 8th tick, rx low -> DATA; rx high -> IDLE (glitch rejected, nothing recorded).
REQ-021 DATA: sample rx every 16 ticks thereafter, shift in LSB first; after 8th bit -> PARITY if enabled, else STOP.
REQ-022 STOP: sample after 16 ticks; high -> byte accepted, IDLE; low -> byte discarded, frame_err set, WAIT_HIGH.
REQ-023 WAIT_HIGH -> IDLE when synchronized rx is high (break condition does not re-trigger).
REQ-024 Accepted bytes SHALL assemble little-endian: byte 0 into [7:0], byte 3 into [31:24]; 2-bit byte counter wraps 3 -> 0.
REQ-025 A discarded byte SHALL NOT advance the byte counter; the partial word is retained.
REQ-026 On 4th accepted byte the word SHALL be written to the FIFO on the next cycle; valid rises that same cycle if previously empty.
REQ-027 rd_en with valid high SHALL pop; data_out shows the next word the following cycle; rd_en with valid low SHALL be ignored.
REQ-028 Push while full without simultaneous pop: word dropped, overrun set, FIFO unchanged.
REQ-029 Simultaneous push and pop (including when full): both performed, level unchanged.
REQ-030 Read/write pointers ADDR_W bits wide, wrap DEPTH-1 -> 0; level = writes minus reads.
REQ-031 clr_err SHALL clear overrun, frame_err, parity_err next cycle; an error event in the same cycle SHALL win (flag stays set).

Reset
REQ-032 While reset is low at a clk edge: FSM IDLE, byte counter 0, partial word 0, pointers 0, level 0, valid 0, full 0, data_out 0, all error flags 0.
REQ-033 Reset mid-frame SHALL discard the in-progress byte and partial word; reception restarts on the next falling edge after release.

Configuration
REQ-034 Macro RX_PARITY_EN defined: PARITY state samples an even-parity bit 16 ticks after bit 7; mismatch -> byte discarded, parity_err set, continue to STOP.
REQ-035 Macro RX_PARITY_EN undefined: no PARITY state, frame is 10 bits, parity_err tied to 0.

Verification
REQ-036 CLK_DIV=4, send bytes 0x78,0x56,0x34,0x12 -> valid=1, data_out=0x12345678, level=1.
REQ-037 Low pulse of 20 clocks on idle rx -> no byte, no flags, FSM back to IDLE.
REQ-038 Byte 0xAA with stop bit low, then 4 good bytes 0x01..0x04 -> frame_err=1, data_out=0x04030201.
REQ-039 DEPTH=16, push 17 words without reads -> full=1, level=16, overrun=1, first pop returns word 0.
REQ-040 Full FIFO, rd_en asserted in push cycle -> level stays 16, overrun=0, order preserved.
REQ-041 RX_PARITY_EN defined, send 0x55 with parity bit 1 -> parity_err=1, byte counter unchanged; clr_err -> parity_err=0.
